// File: rtl/lap_sampler_pkg.sv
// Shared types and constants for the stopwatch lap sampler.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package lap_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int DIGIT_W  = 4;
    localparam int SAMPLE_W = 8;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // True when a BCD digit is at its top value and the next increment must wrap.
    function automatic logic digit_at_max(input logic [DIGIT_W-1:0] digit);
        return (digit == BCD_MAX);
    endfunction

endpackage

// File: rtl/lap_sampler_bcd_digit_ctr.sv
// One BCD digit (0-9) with increment input and ripple carry output.
// Latency: digit updates one cycle after inc; carry_out is combinational from inc.
// Backpressure: none; every inc pulse is counted.
module bcd_digit_ctr
    import lap_sampler_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               carry_out
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next digit: clear has priority, increment wraps 9 -> 0.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = digit_at_max(digit_q) ? '0 : digit_q + DIGIT_W'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_out = digit_q;
    assign carry_out = inc && digit_at_max(digit_q);

endmodule

// File: rtl/lap_sampler.sv
// Stopwatch front end: BCD 00-99 seconds counter with start/stop/clear and lap capture.
// Latency: button press to strobe/state change 1 cycle (DEBOUNCE_CYCLES+2 with LAP_SAMPLER_DEBOUNCE_EN).
// Backpressure: none; the lap stash always accepts, so every capture is a one-cycle strobe.
module lap_sampler
    import lap_sampler_pkg::*;
#(
    parameter int TICKS_PER_UNIT  = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_start,
    input  logic                btn_lap,
    input  logic                btn_clear,
    output logic [SAMPLE_W-1:0] time_out,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                running
);

    localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

    // Button bit order: [0]=start, [1]=lap, [2]=clear.
    logic [2:0] btn_raw;
    logic [2:0] btn_lvl;

    assign btn_raw = {btn_clear, btn_lap, btn_start};

`ifdef LAP_SAMPLER_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [DB_W-1:0] cnt_q;
        logic [DB_W-1:0] cnt_d;
        logic            filt_q;
        logic            filt_d;

        // Count consecutive cycles the raw level disagrees with the filtered one; flip once stable.
        always_comb begin
            cnt_d  = '0;
            filt_d = filt_q;
            if (btn_raw[i] != filt_q) begin
                if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
                    filt_d = btn_raw[i];
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
        end

        // Filtered level resets high so a button held through reset is not a press.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= '0;
                filt_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign btn_lvl[i] = filt_q;
    end
`else
    assign btn_lvl = btn_raw;
`endif

    logic [2:0]          btn_prev_q;
    logic [2:0]          btn_press;
    state_t              state_q;
    state_t              state_d;
    logic [PW-1:0]       presc_q;
    logic [PW-1:0]       presc_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic [SAMPLE_W-1:0] sample_d;
    logic                sample_vld_q;
    logic                sample_vld_d;
    logic                running_q;
    logic                running_d;
    logic                start_p;
    logic                lap_p;
    logic                clr_p;
    logic                tick;
    logic                clear_evt;
    logic                capture;
    logic [DIGIT_W-1:0]  ones_digit;
    logic [DIGIT_W-1:0]  tens_digit;
    logic                ones_carry;
    logic                tens_carry_unused;

    assign btn_press = btn_lvl & ~btn_prev_q;
    assign start_p   = btn_press[0];
    assign lap_p     = btn_press[1];
    assign clr_p     = btn_press[2];

    assign tick      = (state_q == ST_RUN) && (presc_q == PW'(TICKS_PER_UNIT - 1));
    assign clear_evt = (state_q == ST_PAUSE) && clr_p;
    assign capture   = lap_p && ((state_q == ST_RUN) || (state_q == ST_PAUSE));

    // Next-state, prescaler and lap capture, all judged against this cycle's state and time.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_p) state_d = ST_RUN;
            ST_RUN:   if (start_p) state_d = ST_PAUSE;
            ST_PAUSE: begin
                // Clear beats start when both are pressed together.
                if (clr_p) begin
                    state_d = ST_IDLE;
                end else if (start_p) begin
                    state_d = ST_RUN;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        presc_d = presc_q;
        if (clear_evt) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        sample_d     = capture ? time_out : sample_q;
        sample_vld_d = capture;
        running_d    = (state_d == ST_RUN);
    end

    // Control registers; reset drops any pending strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_q   <= 3'b111;
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            btn_prev_q   <= btn_lvl;
            state_q      <= state_d;
            presc_q      <= presc_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            running_q    <= running_d;
        end
    end

    bcd_digit_ctr u_ones (
        .clk       (clk),
        .reset     (reset),
        .clr       (clear_evt),
        .inc       (tick),
        .digit_out (ones_digit),
        .carry_out (ones_carry)
    );

    // Tens carry is dropped: 99 wraps silently to 00.
    bcd_digit_ctr u_tens (
        .clk       (clk),
        .reset     (reset),
        .clr       (clear_evt),
        .inc       (ones_carry),
        .digit_out (tens_digit),
        .carry_out (tens_carry_unused)
    );

    assign time_out     = {tens_digit, ones_digit};
    assign sample_out   = sample_q;
    assign sample_valid = sample_vld_q;
    assign running      = running_q;

endmodule

// File: tb/tb_lap_sampler.sv
// Self-checking bench for lap_sampler with a lap-sample scoreboard.
// Latency: expected strobes carry the cycle they must appear in.
// Backpressure: not applicable.
module tb_lap_sampler;

    localparam int TPU = 4;
    localparam int DBC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clear;
    logic [7:0] time_out;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       running;

    lap_sampler #(
        .TICKS_PER_UNIT  (TPU),
        .DEBOUNCE_CYCLES (DBC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_start    (btn_start),
        .btn_lap      (btn_lap),
        .btn_clear    (btn_clear),
        .time_out     (time_out),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .running      (running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle press of any combination of buttons, then all released.
    task automatic press(input logic s, input logic l, input logic c);
        btn_start = s;
        btn_lap   = l;
        btn_clear = c;
        step(1);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_clear = 1'b0;
    endtask

    // Called in the cycle of a lap press: strobe due in the next cycle (or later with debounce).
    task automatic exp_lap(input logic [7:0] dat, input int lat);
        sb_q.push_back('{dat: dat, cyc: cyc + lat});
    endtask

    task automatic do_reset(input int settle);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(settle);
    endtask

    // Monitor: every strobe must match the head of the scoreboard, value and cycle.
    always @(negedge clk) begin
        if (sample_valid !== 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got sample %h valid %b at cycle %0d, required no strobe",
                         sample_out, sample_valid, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (sample_out !== e.dat || cyc != e.cyc || sample_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL lap_sample: got %h at cycle %0d, required %h at cycle %0d",
                             sample_out, cyc, e.dat, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_clear = 1'b0;

`ifdef LAP_SAMPLER_DEBOUNCE_EN
        do_reset(8);
        chk("db_reset_time", time_out, 8'h00);
        chk("db_reset_running", {7'd0, running}, 8'h00);
        // 2-cycle glitch is shorter than the debounce window.
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        step(8);
        chk("db_glitch_ignored", {7'd0, running}, 8'h00);
        // Clean press: running rises exactly 5 cycles after the raw edge.
        btn_start = 1'b1;
        step(4);
        chk("db_press_plus4", {7'd0, running}, 8'h00);
        step(1);
        chk("db_press_plus5", {7'd0, running}, 8'h01);
        btn_start = 1'b0;
        step(8);
        chk("db_release_no_effect", {7'd0, running}, 8'h01);
        chk("db_time_after_13", time_out, 8'h02);
        btn_start = 1'b1;
        step(5);
        chk("db_paused", {7'd0, running}, 8'h00);
        chk("db_pause_time", time_out, 8'h03);
        btn_start = 1'b0;
        step(8);
        // Debounced lap: strobe DEBOUNCE_CYCLES+2 cycles after the raw edge.
        exp_lap(8'h03, DBC + 2);
        btn_lap = 1'b1;
        step(6);
        btn_lap = 1'b0;
        step(8);
`else
        // 1: reset state, count to 10, lap, start+lap in RUN.
        do_reset(1);
        chk("reset_time", time_out, 8'h00);
        chk("reset_sample", sample_out, 8'h00);
        chk("reset_valid", {7'd0, sample_valid}, 8'h00);
        chk("reset_running", {7'd0, running}, 8'h00);
        press(1'b1, 1'b0, 1'b0);
        step(40);
        chk("run40_time", time_out, 8'h10);
        chk("run40_running", {7'd0, running}, 8'h01);
        exp_lap(8'h10, 1);
        press(1'b0, 1'b1, 1'b0);
        step(1);
        exp_lap(8'h10, 1);
        press(1'b1, 1'b1, 1'b0);
        chk("start_lap_paused", {7'd0, running}, 8'h00);
        chk("start_lap_time", time_out, 8'h10);

        // 2: 99 -> 00 wrap, reset with lap drops strobe, 09 -> 10 carry.
        do_reset(1);
        press(1'b1, 1'b0, 1'b0);
        step(399);
        chk("time_99", time_out, 8'h99);
        step(1);
        chk("wrap_00", time_out, 8'h00);
        btn_lap = 1'b1;
        reset   = 1'b1;
        step(1);
        chk("mid_reset_time", time_out, 8'h00);
        chk("mid_reset_running", {7'd0, running}, 8'h00);
        chk("mid_reset_valid", {7'd0, sample_valid}, 8'h00);
        btn_lap = 1'b0;
        do_reset(1);
        press(1'b1, 1'b0, 1'b0);
        step(39);
        chk("time_09", time_out, 8'h09);
        step(1);
        chk("carry_10", time_out, 8'h10);

        // 3: lap on the tick cycle captures the pre-increment time.
        do_reset(1);
        press(1'b1, 1'b0, 1'b0);
        step(95);
        chk("time_23", time_out, 8'h23);
        exp_lap(8'h23, 1);
        press(1'b0, 1'b1, 1'b0);
        chk("tick_lap_time", time_out, 8'h24);

        // 4: pause holds time and prescaler; clear+start in PAUSE goes IDLE.
        do_reset(1);
        press(1'b1, 1'b0, 1'b0);
        step(21);
        chk("time_05", time_out, 8'h05);
        press(1'b1, 1'b0, 1'b0);
        chk("pause_running", {7'd0, running}, 8'h00);
        step(100);
        chk("pause_hold", time_out, 8'h05);
        press(1'b1, 1'b0, 1'b0);
        chk("resume_running", {7'd0, running}, 8'h01);
        step(1);
        chk("resume_plus1", time_out, 8'h05);
        step(1);
        chk("resume_plus2", time_out, 8'h06);
        press(1'b1, 1'b0, 1'b0);
        step(1);
        press(1'b1, 1'b0, 1'b1);
        chk("clr_start_running", {7'd0, running}, 8'h00);
        chk("clr_start_time", time_out, 8'h00);
        step(2);
        press(1'b1, 1'b0, 1'b0);
        step(3);
        chk("presc_cleared_a", time_out, 8'h00);
        step(1);
        chk("presc_cleared_b", time_out, 8'h01);

        // 5: lap held through reset, lap in IDLE, laps in PAUSE, clear+lap, clear in RUN.
        btn_lap = 1'b1;
        reset   = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        btn_lap = 1'b0;
        step(1);
        press(1'b0, 1'b1, 1'b0);
        step(2);
        press(1'b1, 1'b0, 1'b0);
        step(9);
        press(1'b1, 1'b0, 1'b0);
        step(1);
        exp_lap(8'h02, 1);
        press(1'b0, 1'b1, 1'b0);
        step(1);
        exp_lap(8'h02, 1);
        press(1'b0, 1'b1, 1'b1);
        chk("clr_lap_time", time_out, 8'h00);
        chk("clr_lap_running", {7'd0, running}, 8'h00);
        step(3);
        press(1'b1, 1'b0, 1'b0);
        step(5);
        press(1'b0, 1'b0, 1'b1);
        chk("clr_in_run_running", {7'd0, running}, 8'h01);
        chk("clr_in_run_time", time_out, 8'h01);
`endif

        step(3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobe: got %0d outstanding samples, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
